mem_port_arbiter: RTL and testbench

//  Shares the single-port data/instruction memory between two requesters:

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port memory: CPU (port 0) and loader/debug (port 1).
// Registered memory issue stage, tag pipe routing read data back to the owning port.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);

  logic                    pri_r;
  logic                    last_port_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [READ_LATENCY-1:0] tag_valid_r;
  logic [READ_LATENCY-1:0] tag_port_r;
  logic                    rvalid0_r;
  logic                    rvalid1_r;
  logic [ADDR_W-1:0]       mem_address_r;
  logic                    mem_write_en_r;
  logic [DATA_W-1:0]       mem_write_data_r;

  logic                    gnt0_s;
  logic                    gnt1_s;
  logic                    win_s;
  logic                    grant_s;
  logic                    other_req_s;
  logic                    sel_we_s;
  logic [ADDR_W-1:0]       sel_addr_s;
  logic [DATA_W-1:0]       sel_wdata_s;
  logic [CNT_W-1:0]        cnt_inc_s;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic                    pri_nxt_s;
  logic [READ_LATENCY-1:0] tag_valid_nxt_s;
  logic [READ_LATENCY-1:0] tag_port_nxt_s;

  // Winner selection: a lone requester wins, a tie goes to pri_r; nothing is granted in reset.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    win_s  = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0 && req1) begin
      win_s  = pri_r;
      gnt0_s = ~pri_r;
      gnt1_s = pri_r;
    end else if (req0) begin
      gnt0_s = 1'b1;
    end else if (req1) begin
      win_s  = 1'b1;
      gnt1_s = 1'b1;
    end else begin
      win_s  = 1'b0;
    end
  end

  assign grant_s     = gnt0_s | gnt1_s;
  assign other_req_s = win_s ? req0 : req1;
  assign sel_we_s    = win_s ? we1 : we0;
  assign sel_addr_s  = win_s ? addr1 : addr0;
  assign sel_wdata_s = win_s ? wdata1 : wdata0;

  // Streak counting and fairness: a streak of MAX_BURST against a waiting port hands priority over.
  always_comb begin
    cnt_inc_s = CNT_ONE;
    pri_nxt_s = pri_r;
    cnt_nxt_s = CNT_ZERO;
    if ((cnt_r != CNT_ZERO) && (last_port_r == win_s)) begin
      cnt_inc_s = (cnt_r >= CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);
    end else begin
      cnt_inc_s = CNT_ONE;
    end
    if (!grant_s) begin
      pri_nxt_s = pri_r;
      cnt_nxt_s = CNT_ZERO;
    end else if (!other_req_s) begin
      pri_nxt_s = win_s;
      cnt_nxt_s = cnt_inc_s;
    end else if (cnt_inc_s == CNT_MAX) begin
      pri_nxt_s = ~win_s;
      cnt_nxt_s = CNT_ZERO;
    end else begin
      pri_nxt_s = pri_r;
      cnt_nxt_s = cnt_inc_s;
    end
  end

  // Next tag-pipe contents: new read tag enters stage 0, older tags move one stage on.
  always_comb begin
    tag_valid_nxt_s    = tag_valid_r;
    tag_port_nxt_s     = tag_port_r;
    tag_valid_nxt_s[0] = grant_s & ~sel_we_s;
    tag_port_nxt_s[0]  = win_s;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_valid_nxt_s[i] = tag_valid_r[i-1];
      tag_port_nxt_s[i]  = tag_port_r[i-1];
    end
  end

  // State, issue stage and read-return registers; reset discards in-flight work.
  always_ff @(posedge clk) begin
    if (reset) begin
      pri_r            <= 1'b0;
      last_port_r      <= 1'b0;
      cnt_r            <= CNT_ZERO;
      tag_valid_r      <= {READ_LATENCY{1'b0}};
      tag_port_r       <= {READ_LATENCY{1'b0}};
      rvalid0_r        <= 1'b0;
      rvalid1_r        <= 1'b0;
      mem_address_r    <= {ADDR_W{1'b0}};
      mem_write_en_r   <= 1'b0;
      mem_write_data_r <= {DATA_W{1'b0}};
    end else begin
      pri_r       <= pri_nxt_s;
      cnt_r       <= cnt_nxt_s;
      tag_valid_r <= tag_valid_nxt_s;
      tag_port_r  <= tag_port_nxt_s;
      rvalid0_r   <= tag_valid_r[READ_LATENCY-1] & ~tag_port_r[READ_LATENCY-1];
      rvalid1_r   <= tag_valid_r[READ_LATENCY-1] & tag_port_r[READ_LATENCY-1];
      if (grant_s) begin
        last_port_r      <= win_s;
        mem_address_r    <= sel_addr_s;
        mem_write_en_r   <= sel_we_s;
        mem_write_data_r <= sel_wdata_s;
      end else begin
        mem_write_en_r   <= 1'b0;
      end
    end
  end

  assign gnt0           = gnt0_s;
  assign gnt1           = gnt1_s;
  assign rvalid0        = rvalid0_r;
  assign rvalid1        = rvalid1_r;
  assign rdata0         = mem_read_data;
  assign rdata1         = mem_read_data;
  assign mem_address    = mem_address_r;
  assign mem_write_en   = mem_write_en_r;
  assign mem_write_data = mem_write_data_r;
  assign busy           = (|tag_valid_r) | mem_write_en_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A (READ_LATENCY=1, MAX_BURST=4) and
// instance B (READ_LATENCY=3, MAX_BURST=1), each with a small memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] addr);
    return 32'hC0DE_0000 ^ addr;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic        a_req0 = 1'b0, a_req1 = 1'b0, a_we0 = 1'b0, a_we1 = 1'b0;
  logic [31:0] a_addr0 = 32'h0, a_addr1 = 32'h0, a_wdata0 = 32'h0, a_wdata1 = 32'h0;
  logic        a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_mem_we, a_busy;
  logic [31:0] a_rdata0, a_rdata1, a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_req0 = 1'b0, b_req1 = 1'b0, b_we0 = 1'b0, b_we1 = 1'b0;
  logic [31:0] b_addr0 = 32'h0, b_addr1 = 32'h0, b_wdata0 = 32'h0, b_wdata1 = 32'h0;
  logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_we, b_busy;
  logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .MAX_BURST(4)) u_a (
    .clk(clk), .reset(reset),
    .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
    .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wdata0), .wdata1(a_wdata1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rvalid0), .rvalid1(a_rvalid1),
    .rdata0(a_rdata0), .rdata1(a_rdata1),
    .mem_address(a_mem_addr), .mem_write_en(a_mem_we), .mem_write_data(a_mem_wdata),
    .mem_read_data(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3), .MAX_BURST(1)) u_b (
    .clk(clk), .reset(reset),
    .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata0(b_rdata0), .rdata1(b_rdata1),
    .mem_address(b_mem_addr), .mem_write_en(b_mem_we), .mem_write_data(b_mem_wdata),
    .mem_read_data(b_mem_rdata), .busy(b_busy)
  );

  // Memory models: unwritten words read as init_val(addr); A has 1-cycle, B 3-cycle read latency.
  bit   [31:0] a_mem_data [256];
  bit          a_mem_wr   [256];
  bit   [31:0] b_mem_data [256];
  bit          b_mem_wr   [256];
  logic [31:0] b_pipe     [3];

  always @(posedge clk) begin
    if (a_mem_we) begin
      a_mem_data[a_mem_addr[9:2]] <= a_mem_wdata;
      a_mem_wr[a_mem_addr[9:2]]   <= 1'b1;
    end
    a_mem_rdata <= a_mem_wr[a_mem_addr[9:2]] ? a_mem_data[a_mem_addr[9:2]] : init_val(a_mem_addr);
  end

  always @(posedge clk) begin
    if (b_mem_we) begin
      b_mem_data[b_mem_addr[9:2]] <= b_mem_wdata;
      b_mem_wr[b_mem_addr[9:2]]   <= 1'b1;
    end
    b_pipe[0] <= b_mem_wr[b_mem_addr[9:2]] ? b_mem_data[b_mem_addr[9:2]] : init_val(b_mem_addr);
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end

  assign b_mem_rdata = b_pipe[2];

  initial begin
    int          n0;
    int          n1;
    logic [5:0]  bpat;
    logic [11:0] apat;
    logic [31:0] b_exp_addr [6];
    logic [31:0] rd;

    bpat = 6'b101010;
    apat = 12'b0000_1111_0000;
    b_exp_addr = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};

    // Reset: grants forced low even with requests raised, then reset values.
    @(negedge clk);
    reset = 1'b1; a_req0 = 1'b1; a_req1 = 1'b1;
    #1;
    chk("rst_gnt0", a_gnt0, 32'd0);
    chk("rst_gnt1", a_gnt1, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_mem_addr", a_mem_addr, 32'h0);
    chk("rst_mem_we", a_mem_we, 32'd0);
    chk("rst_mem_wdata", a_mem_wdata, 32'h0);
    chk("rst_rvalid0", a_rvalid0, 32'd0);
    chk("rst_rvalid1", a_rvalid1, 32'd0);
    chk("rst_busy", a_busy, 32'd0);
    chk("rst_b_busy", b_busy, 32'd0);
    @(negedge clk);
    reset = 1'b0; a_req0 = 1'b0; a_req1 = 1'b0;

    // B: MAX_BURST=1 strict alternation, READ_LATENCY=3 returns in accept order, no bubbles.
    n0 = 0; n1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b_req0  = (n0 < 3);
      b_req1  = (n1 < 3);
      b_addr0 = 32'h100 + 32'(n0 * 4);
      b_addr1 = 32'h200 + 32'(n1 * 4);
      #1;
      if (i < 6) begin
        chk($sformatf("b_gnt0_%0d", i), b_gnt0, {31'd0, !bpat[i]});
        chk($sformatf("b_gnt1_%0d", i), b_gnt1, {31'd0, bpat[i]});
      end
      if (i == 3) begin
        chk("b_rvalid0_early", b_rvalid0, 32'd0);
        chk("b_rvalid1_early", b_rvalid1, 32'd0);
      end
      if (i == 5) chk("b_busy_active", b_busy, 32'd1);
      if (i >= 4) begin
        chk($sformatf("b_rvalid0_%0d", i), b_rvalid0, {31'd0, !bpat[i-4]});
        chk($sformatf("b_rvalid1_%0d", i), b_rvalid1, {31'd0, bpat[i-4]});
        rd = bpat[i-4] ? b_rdata1 : b_rdata0;
        chk($sformatf("b_rdata_%0d", i), rd, init_val(b_exp_addr[i-4]));
      end
      if (i == 9) chk("b_busy_drained", b_busy, 32'd0);
      if (b_gnt0) n0++;
      if (b_gnt1) n1++;
    end
    b_req0 = 1'b0; b_req1 = 1'b0;

    // A: single read by port 0, rvalid two cycles after accept.
    @(negedge clk);
    a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 32'h10;
    #1;
    chk("t1_gnt0", a_gnt0, 32'd1);
    chk("t1_gnt1", a_gnt1, 32'd0);
    @(negedge clk);
    a_req0 = 1'b0;
    #1;
    chk("t1_mem_addr", a_mem_addr, 32'h10);
    chk("t1_mem_we", a_mem_we, 32'd0);
    chk("t1_busy", a_busy, 32'd1);
    chk("t1_rvalid0_early", a_rvalid0, 32'd0);
    @(negedge clk);
    #1;
    chk("t1_rvalid0", a_rvalid0, 32'd1);
    chk("t1_rdata0", a_rdata0, init_val(32'h10));
    chk("t1_rvalid1", a_rvalid1, 32'd0);
    chk("t1_busy_idle", a_busy, 32'd0);
    @(negedge clk);
    #1;
    chk("t1_rvalid0_done", a_rvalid0, 32'd0);

    // A: both ports held 12 cycles, bursts of four, reads routed back to the right port.
    a_addr0 = 32'h20; a_addr1 = 32'h24; a_we0 = 1'b0; a_we1 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      a_req0 = (i < 12);
      a_req1 = (i < 12);
      #1;
      if (i < 12) begin
        chk($sformatf("t2_gnt0_%0d", i), a_gnt0, {31'd0, !apat[i]});
        chk($sformatf("t2_gnt1_%0d", i), a_gnt1, {31'd0, apat[i]});
      end
      if (i >= 2) begin
        chk($sformatf("t2_rvalid0_%0d", i), a_rvalid0, {31'd0, !apat[i-2]});
        chk($sformatf("t2_rvalid1_%0d", i), a_rvalid1, {31'd0, apat[i-2]});
        rd = apat[i-2] ? a_rdata1 : a_rdata0;
        chk($sformatf("t2_rdata_%0d", i), rd, apat[i-2] ? init_val(32'h24) : init_val(32'h20));
      end
    end

    // A: port 1 writes, port 0 reads the same word back next cycle.
    @(negedge clk);
    a_req0 = 1'b0; a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 32'h40; a_wdata1 = 32'hDEAD_BEEF;
    #1;
    chk("t4_gnt1", a_gnt1, 32'd1);
    chk("t4_gnt0", a_gnt0, 32'd0);
    @(negedge clk);
    a_req1 = 1'b0; a_we1 = 1'b0; a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 32'h40;
    #1;
    chk("t4_gnt0_rd", a_gnt0, 32'd1);
    chk("t4_mem_we", a_mem_we, 32'd1);
    chk("t4_mem_addr", a_mem_addr, 32'h40);
    chk("t4_mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    chk("t4_busy", a_busy, 32'd1);
    @(negedge clk);
    a_req0 = 1'b0;
    #1;
    chk("t4_mem_we_off", a_mem_we, 32'd0);
    chk("t4_rvalid1_wr", a_rvalid1, 32'd0);
    chk("t4_rvalid0_early", a_rvalid0, 32'd0);
    @(negedge clk);
    #1;
    chk("t4_rvalid0", a_rvalid0, 32'd1);
    chk("t4_rdata0", a_rdata0, 32'hDEAD_BEEF);
    chk("t4_rvalid1", a_rvalid1, 32'd0);
    chk("t4_addr_hold", a_mem_addr, 32'h40);

    // A: read in flight discarded by reset; first tie afterwards goes to port 0.
    @(negedge clk);
    a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 32'h30;
    #1;
    chk("t5_gnt1", a_gnt1, 32'd1);
    @(negedge clk);
    reset = 1'b1; a_req0 = 1'b1; a_addr0 = 32'h34; a_addr1 = 32'h38;
    #1;
    chk("t5_rst_gnt0", a_gnt0, 32'd0);
    chk("t5_rst_gnt1", a_gnt1, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_rvalid1", a_rvalid1, 32'd0);
    chk("t5_rvalid0", a_rvalid0, 32'd0);
    chk("t5_mem_addr", a_mem_addr, 32'h0);
    chk("t5_mem_we", a_mem_we, 32'd0);
    chk("t5_busy", a_busy, 32'd0);
    chk("t5_tie_gnt0", a_gnt0, 32'd1);
    chk("t5_tie_gnt1", a_gnt1, 32'd0);
    @(negedge clk);
    a_req0 = 1'b0; a_req1 = 1'b0;
    #1;
    chk("t5_mem_addr_win", a_mem_addr, 32'h34);
    @(negedge clk);
    #1;
    chk("t5_rvalid0_after", a_rvalid0, 32'd1);
    chk("t5_rdata0_after", a_rdata0, init_val(32'h34));
    chk("t5_rvalid1_after", a_rvalid1, 32'd0);

    // A: write in the issue stage when reset arrives is not repeated afterwards.
    @(negedge clk);
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 32'h50; a_wdata1 = 32'h1234_5678;
    #1;
    chk("t5w_gnt1", a_gnt1, 32'd1);
    @(negedge clk);
    reset = 1'b1; a_req1 = 1'b0; a_we1 = 1'b0;
    #1;
    chk("t5w_mem_we_issue", a_mem_we, 32'd1);
    @(negedge clk);
    reset = 1'b0; a_req0 = 1'b1; a_req1 = 1'b1; a_addr0 = 32'h60; a_addr1 = 32'h64;
    #1;
    chk("t5w_mem_we_after", a_mem_we, 32'd0);
    chk("t5w_mem_wdata", a_mem_wdata, 32'h0);
    chk("t5w_busy", a_busy, 32'd0);
    chk("t5w_tie_gnt0", a_gnt0, 32'd1);
    chk("t5w_tie_gnt1", a_gnt1, 32'd0);
    @(negedge clk);
    a_req0 = 1'b0; a_req1 = 1'b0;
    #1;
    chk("t5w_mem_addr", a_mem_addr, 32'h60);
    chk("t5w_mem_we_rd", a_mem_we, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
